mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one single-port 32-bit RAM/bus between two requesters: the instruction-fetch path (read-only) and the MEM-stage load/store path (byte-select, read/write).
- Sits between the pipeline and the RAM.
- Arbitrates, latches the winning request, waits for a RAM acknowledge, returns read data, and raises a stall request to pipeline control while any access is outstanding.
- Enforces a bounded wait via a timeout.

Parameters:
TIMEOUT, 255, max GRANT cycles without ram_ack_i before abort (must be ≥1)
CNT_W, 8, width of wait counter; must hold TIMEOUT

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
if_ce_i  input  1  instruction fetch request
if_addr_i  input  32  fetch address
if_data_o  output  32  fetched word
if_ack_o  output  1  one-cycle completion pulse, fetch
d_ce_i  input  1  data request
d_we_i  input  1  1 = store, 0 = load
d_addr_i  input  32  data address
d_sel_i  input  4  byte lane enables
d_data_i  input  32  store data
d_data_o  output  32  load data
d_ack_o  output  1  one-cycle completion pulse, data
ram_ce_o  output  1  RAM chip enable
ram_we_o  output  1  RAM write enable
ram_addr_o  output  32  RAM address
ram_sel_o  output  4  RAM byte lanes
ram_data_o  output  32  RAM write data
ram_data_i  input  32  RAM read data
ram_ack_i  input  1  RAM completion
bus_err_o  output  1  one-cycle pulse with ack on timeout abort
stall_req_o  output  1  pipeline stall request

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, owner=none. All outputs are 0: ram_ce_o drops immediately, ram_sel_o=4'b0000, data outputs and acks are 0. Reset mid-transaction abandons the transaction with no ack.
- FSM states: IDLE, GRANT_D, GRANT_I, DONE.
- IDLE:
  - If d_ce_i=1 → GRANT_D. Data has fixed priority: the MEM stage is older in the pipeline.
  - Else if if_ce_i=1 → GRANT_I.
  - Else stay in IDLE.
  - On leaving IDLE, latch addr/we/sel/wdata. A fetch is latched as we=0, sel=4'b1111, wdata=0.
- GRANT_x:
  - ram_ce_o=1; ram_we_o/addr/sel/data are driven from latched registers only.
  - Requester input changes or deasserts are ignored; the transaction always completes.
  - Counter increments each GRANT cycle.
  - On ram_ack_i=1: capture ram_data_i into the owner's data output (loads and fetches only; d_data_o is unchanged on a store) → DONE.
  - If the counter reaches TIMEOUT with no ack: drive the owner's data output to 0, set an error flag → DONE.
  - If ram_ack_i arrives in the same cycle as the timeout, the ack wins: no error, data captured.
  - Earliest ack is in the first GRANT cycle.
- DONE (exactly one cycle):
  - ram_ce_o=0, ram_sel_o=0.
  - The owner's ack_o=1; bus_err_o=1 if the error flag is set.
  - Counter and flag clear → IDLE.
  - Acks and bus_err_o are registered, one-cycle pulses that never overlap.
- Timing:
  - Minimum transaction is 3 cycles: IDLE sample → GRANT → DONE.
  - A requester sees ack in DONE and updates its request at the following edge, so IDLE never re-samples a completed request.
- Data outputs hold their last captured value until the next capture for the same owner.
- stall_req_o is combinational: (d_ce_i | if_ce_i) AND NOT (state==DONE AND that requester is the owner AND the other requester's ce=0).
  - It is 1 while either request is pending and unserved.
  - It is 0 when no request is pending.
- Back-to-back with both requesting: D is granted first, then I after D's DONE+IDLE. Fetch is delayed by ≥3 cycles.

Test Plan:
- Reset mid-operation: rst=0 during GRANT_D with ram_ce_o=1 → same-cycle ram_ce_o=0, all outputs 0. After release, with no requests, state stays IDLE.
- Single fetch: if_ce_i=1, if_addr_i=0x00000040, RAM acks on first GRANT cycle with 0x3C010001 → ram_ce_o high for 1 cycle, ram_sel_o=1111, ram_we_o=0. if_ack_o pulses 1 cycle with if_data_o=0x3C010001, total 3 cycles.
- Byte store: d_ce_i=1, d_we_i=1, d_addr_i=0x103, d_sel_i=1000, d_data_i=0xAB000000, ack after 2 wait cycles → ram_we_o=1, ram_sel_o=1000 held 3 cycles. d_ack_o pulses, d_data_o unchanged, stall_req_o=1 until the DONE cycle.
- Simultaneous requests: if_ce_i=d_ce_i=1 in IDLE → data is served first (ram_addr_o=d_addr_i), then fetch. if_ack_o comes 3+ cycles after d_ack_o, and the acks never share a cycle.
- Timeout: TIMEOUT=4, d load with ram_ack_i never asserted → 4 GRANT cycles, then d_ack_o=1, bus_err_o=1, d_data_o=0. Repeat with ram_ack_i in the 4th cycle → no error, data captured.
- Request changes during GRANT: d_addr_i changes mid-GRANT from 0x200 to 0x300 → ram_addr_o remains 0x200 until DONE.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter : shares one single-port RAM between fetch and load/store
// Revision        : 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,
  input  logic        d_ce_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_data_i,
  output logic [31:0] d_data_o,
  output logic        d_ack_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i,
  input  logic        ram_ack_i,
  output logic        bus_err_o,
  output logic        stall_req_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  wait_cnt;
  logic              own_d;
  logic              own_i;
  logic              err_flag;
  logic              ack_d;
  logic              ack_i;
  logic              lat_we;
  logic [31:0]       lat_addr;
  logic [3:0]        lat_sel;
  logic [31:0]       lat_wdata;
  logic [31:0]       if_data;
  logic [31:0]       d_data;
  logic              granted;
  logic              timeout_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    granted     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (d_ce_i)       state_nx = GRANT_D;
        else if (if_ce_i) state_nx = GRANT_I;
      end
      GRANT_D, GRANT_I: begin
        granted = 1'b1;
        // An ack arriving on the last allowed cycle takes precedence over the abort
        if (ram_ack_i) begin
          state_nx = DONE;
        end else if (wait_cnt == LAST_WAIT) begin
          state_nx    = DONE;
          timeout_hit = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      own_d     <= 1'b0;
      own_i     <= 1'b0;
      err_flag  <= 1'b0;
      ack_d     <= 1'b0;
      ack_i     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_sel   <= '0;
      lat_wdata <= '0;
      if_data   <= '0;
      d_data    <= '0;
    end else begin
      ack_d <= 1'b0;
      ack_i <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (d_ce_i) begin
            own_d     <= 1'b1;
            own_i     <= 1'b0;
            lat_we    <= d_we_i;
            lat_addr  <= d_addr_i;
            lat_sel   <= d_sel_i;
            lat_wdata <= d_data_i;
          end else if (if_ce_i) begin
            own_d     <= 1'b0;
            own_i     <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= if_addr_i;
            lat_sel   <= 4'b1111;
            lat_wdata <= '0;
          end
        end
        GRANT_D, GRANT_I: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (ram_ack_i) begin
            ack_d <= own_d;
            ack_i <= own_i;
            if (own_i)               if_data <= ram_data_i;
            if (own_d && !lat_we)    d_data  <= ram_data_i;
          end else if (timeout_hit) begin
            ack_d    <= own_d;
            ack_i    <= own_i;
            err_flag <= 1'b1;
            if (own_i) if_data <= '0;
            if (own_d) d_data  <= '0;
          end
        end
        DONE: begin
          wait_cnt <= '0;
          err_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ram_ce_o   = granted;
  assign ram_we_o   = granted & lat_we;
  assign ram_addr_o = granted ? lat_addr  : '0;
  assign ram_sel_o  = granted ? lat_sel   : '0;
  assign ram_data_o = granted ? lat_wdata : '0;

  assign if_data_o  = if_data;
  assign d_data_o   = d_data;
  assign if_ack_o   = ack_i;
  assign d_ack_o    = ack_d;
  assign bus_err_o  = err_flag;

  // Held low during reset so every output is quiet while rst is asserted
  assign stall_req_o = rst & (d_ce_i | if_ce_i) &
                       ~((state == DONE) & ((own_d & ~if_ce_i) | (own_i & ~d_ce_i)));

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// tb_mem_bus_arbiter : randomized transaction-timeline check of mem_bus_arbiter
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        d_ce_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [3:0]  d_sel_i;
  logic [31:0] d_data_i;
  logic [31:0] d_data_o;
  logic        d_ack_o;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i;
  logic        ram_ack_i;
  logic        bus_err_o;
  logic        stall_req_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_d_data;
  logic [31:0] exp_i_data;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(T), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .d_ce_i(d_ce_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_sel_i(d_sel_i),
    .d_data_i(d_data_i), .d_data_o(d_data_o), .d_ack_o(d_ack_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_sel_o(ram_sel_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i), .ram_ack_i(ram_ack_i),
    .bus_err_o(bus_err_o), .stall_req_o(stall_req_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Timeline: a transaction whose IDLE sample cycle is s and which waits g
  // cycles is granted during (s, s+g] and acknowledges in cycle s+g+1.
  task automatic run_txn(input bit rd, input bit ri, input logic dwe,
                         input logic [31:0] dad, input logic [3:0] dsel, input logic [31:0] dwd,
                         input logic [31:0] iad, input int latd, input int lati,
                         input logic [31:0] rdd, input logic [31:0] rdi);
    int gd, gi, ds, dd, is0, id, last;
    gd   = (latd < T) ? latd : T;
    gi   = (lati < T) ? lati : T;
    ds   = 0;
    dd   = rd ? gd + 1 : -10;
    is0  = rd ? dd + 1 : 0;
    id   = ri ? is0 + gi + 1 : -10;
    last = ((dd > id) ? dd : id) + 1;
    for (int c = 0; c <= last; c++) begin
      bit dce, ice, dgr, igr, dfin, ifin;
      @(posedge clk); #1;
      dce  = rd && (c <= dd);
      ice  = ri && (c <= id);
      dgr  = rd && (c > ds)  && (c <= ds + gd);
      igr  = ri && (c > is0) && (c <= is0 + gi);
      dfin = rd && (c == dd);
      ifin = ri && (c == id);
      d_ce_i  = dce;
      if_ce_i = ice;
      if (c == 0) begin
        d_we_i = dwe; d_addr_i = dad; d_sel_i = dsel; d_data_i = dwd;
      end else begin
        d_we_i = 1'($urandom); d_addr_i = $urandom; d_sel_i = 4'($urandom); d_data_i = $urandom;
      end
      if_addr_i  = (c <= is0) ? iad : $urandom;
      ram_ack_i  = (dgr && c == ds + latd) || (igr && c == is0 + lati);
      ram_data_i = ram_ack_i ? (dgr ? rdd : rdi) : $urandom;
      @(negedge clk);
      if (dfin) exp_d_data = (latd > T) ? 32'h0 : (dwe ? exp_d_data : rdd);
      if (ifin) exp_i_data = (lati > T) ? 32'h0 : rdi;
      check("ram_ce", 32'(ram_ce_o), 32'(dgr | igr));
      if (dgr || igr) begin
        check("ram_addr", ram_addr_o, dgr ? dad : iad);
        check("ram_we",   32'(ram_we_o), dgr ? 32'(dwe) : 32'h0);
        check("ram_sel",  32'(ram_sel_o), dgr ? 32'(dsel) : 32'hF);
        check("ram_wdata", ram_data_o, dgr ? dwd : 32'h0);
      end else begin
        check("ram_sel_idle", 32'(ram_sel_o), 32'h0);
      end
      check("d_ack",   32'(d_ack_o),  32'(dfin));
      check("if_ack",  32'(if_ack_o), 32'(ifin));
      check("bus_err", 32'(bus_err_o), 32'((dfin && latd > T) || (ifin && lati > T)));
      check("d_data",  d_data_o,  exp_d_data);
      check("if_data", if_data_o, exp_i_data);
      check("stall",   32'(stall_req_o),
            32'((dce | ice) && !((dfin && !ice) || (ifin && !dce))));
    end
  endtask

  task automatic reset_mid_grant();
    @(posedge clk); #1;
    d_ce_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h500; d_sel_i = 4'hF; ram_ack_i = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_ce", 32'(ram_ce_o), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("rst_ce",    32'(ram_ce_o),    32'h0);
    check("rst_sel",   32'(ram_sel_o),   32'h0);
    check("rst_addr",  ram_addr_o,       32'h0);
    check("rst_stall", 32'(stall_req_o), 32'h0);
    check("rst_dack",  32'(d_ack_o),     32'h0);
    check("rst_ddata", d_data_o,         32'h0);
    check("rst_idata", if_data_o,        32'h0);
    d_ce_i = 1'b0;
    exp_d_data = 32'h0;
    exp_i_data = 32'h0;
    @(negedge clk); rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle_ce", 32'(ram_ce_o), 32'h0);
      check("post_rst_dack",    32'(d_ack_o),  32'h0);
    end
  endtask

  initial begin
    rst = 1'b0;
    if_ce_i = 1'b0; if_addr_i = '0; d_ce_i = 1'b0; d_we_i = 1'b0;
    d_addr_i = '0; d_sel_i = '0; d_data_i = '0; ram_data_i = '0; ram_ack_i = 1'b0;
    exp_d_data = 32'h0;
    exp_i_data = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_ce",    32'(ram_ce_o),  32'h0);
    check("reset_sel",   32'(ram_sel_o), 32'h0);
    check("reset_acks",  32'({d_ack_o, if_ack_o, bus_err_o}), 32'h0);
    check("reset_ddata", d_data_o, 32'h0);
    rst = 1'b1;

    run_txn(0, 1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0000_0040, 1, 1, 32'h0, 32'h3C01_0001);
    run_txn(1, 0, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'h0, 1, 1, 32'h1234_5678, 32'h0);
    run_txn(1, 0, 1'b1, 32'h0000_0103, 4'b1000, 32'hAB00_0000, 32'h0, 3, 1, 32'hDEAD_BEEF, 32'h0);
    run_txn(1, 1, 1'b0, 32'h0000_0204, 4'hF, 32'h0, 32'h0000_0080, 2, 1, 32'h5555_AAAA, 32'h0F0F_0F0F);
    run_txn(1, 0, 1'b0, 32'h0000_0300, 4'hF, 32'h0, 32'h0, T + 1, 1, 32'hCAFE_0001, 32'h0);
    run_txn(1, 0, 1'b0, 32'h0000_0304, 4'hF, 32'h0, 32'h0, T, 1, 32'hCAFE_0002, 32'h0);
    run_txn(1, 0, 1'b0, 32'h0000_0200, 4'hF, 32'h0, 32'h0, 3, 1, 32'h0000_0200, 32'h0);
    run_txn(0, 1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0000_0044, 1, T + 1, 32'h0, 32'h7777_7777);
    run_txn(1, 1, 1'b1, 32'h0000_0400, 4'b0011, 32'h0000_BEEF, 32'h0000_0048, T + 1, T, 32'h1, 32'h2);

    reset_mid_grant();

    for (int k = 0; k < 40; k++) begin
      bit rd, ri;
      rd = 1'($urandom_range(0, 1));
      ri = 1'($urandom_range(0, 1));
      if (!rd && !ri) ri = 1'b1;
      run_txn(rd, ri, 1'($urandom), $urandom, 4'($urandom), $urandom, $urandom,
              $urandom_range(1, T + 1), $urandom_range(1, T + 1), $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
